// File: rtl/adsb_pkg.sv
// Shared constants and types for the ADS-B squitter decoder.
//   LONG_BITS/SHORT_BITS : extended / short squitter lengths
//   DF_LONG_MIN          : smallest downlink format carried in a long frame
//   CRC_POLY             : CRC-24 generator with the implicit x^24 dropped
//   TUSER_*              : field positions inside m00_axis_tuser
package adsb_pkg;

  localparam int unsigned LONG_BITS   = 112;
  localparam int unsigned SHORT_BITS  = 56;
  localparam int unsigned DF_LONG_MIN = 16;
  localparam int unsigned BIT_W       = $clog2(LONG_BITS);

  localparam int unsigned CRC_W = 24;
  localparam logic [CRC_W-1:0] CRC_POLY = 24'hFFF409;

  localparam int unsigned TUSER_W        = 8;
  localparam int unsigned TUSER_LONG     = 0;
  localparam int unsigned TUSER_CRC_OK   = 1;
  localparam int unsigned TUSER_VIOL_LSB = 2;
  localparam int unsigned VIOL_W         = TUSER_W - TUSER_VIOL_LSB;

  // Decoder FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE        = 2'd0;
  localparam state_t ST_FIRST_CHIP  = 2'd1;
  localparam state_t ST_SECOND_CHIP = 2'd2;

  // One step of the MSB-first, non-reflected CRC-24 shift register
  function automatic logic [CRC_W-1:0] crc24_step(input logic [CRC_W-1:0] crc,
                                                   input logic            din);
    logic fb;
    fb = din ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/adsb_frame_decoder_if.sv
// Decoded-frame AXI-Stream bundle.
//   tvalid/tready : handshake
//   tdata         : 112-bit frame, first received bit in MSB
//   tuser         : [0] long frame, [1] crc_ok, [7:2] violation count
//   tlast         : every beat is a whole frame
interface adsb_frame_decoder_if;

  logic                                  tvalid;
  logic                                  tready;
  logic [adsb_pkg::LONG_BITS-1:0]        tdata;
  logic [adsb_pkg::TUSER_W-1:0]          tuser;
  logic                                  tlast;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);

endinterface

// File: rtl/adsb_crc24.sv
// Bit-serial CRC-24 accumulator.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : restart the remainder at zero
//   en, din    : shift one message bit in
//   crc_next_c : remainder including din, valid in the same cycle as en
module adsb_crc24
  import adsb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc_next_c
);

  logic [CRC_W-1:0] crc;

  assign crc_next_c = crc24_step(crc, din);

  always_ff @(posedge clk) begin
    if (rst || clr) crc <= '0;
    else if (en)    crc <= crc_next_c;
  end

endmodule

// File: rtl/adsb_frame_decoder.sv
// PPM squitter decoder: samples each 0.5 us chip mid-period after a preamble
// trigger, picks the 56/112-bit length from the DF field, aborts frames with
// too many chip-pair violations and holds the result in a one-entry AXIS
// output register.
//   s00_axis_aclk / s00_axis_areset : clock, synchronous active-high reset
//   s00_axis_tdata, decoder_threshold : magnitude stream and slicing level
//   s00_axis_tvalid (ignored), s00_axis_tready (tied 1)
//   trigger   : preamble-detected pulse
//   m00_axis  : decoded frame stream (adsb_frame_decoder_if master)
//   frame_abort / frame_overflow : one-cycle event pulses
// Define ADSB_CRC_EN to compute crc_ok with a serial CRC-24; otherwise it is 0.
module adsb_frame_decoder
  import adsb_pkg::*;
#(
  parameter int unsigned MAG_WIDTH        = 32,
  parameter int unsigned SAMPLES_PER_CHIP = 32,
  parameter int unsigned TRIGGER_DELAY    = 3,
  parameter int unsigned MAX_ERRORS       = 4
)(
  input  logic                 s00_axis_aclk,
  input  logic                 s00_axis_areset,
  input  logic                 s00_axis_tvalid,
  input  logic [MAG_WIDTH-1:0] s00_axis_tdata,
  output logic                 s00_axis_tready,
  input  logic                 trigger,
  input  logic [MAG_WIDTH-1:0] decoder_threshold,
  adsb_frame_decoder_if.master m00_axis,
  output logic                 frame_abort,
  output logic                 frame_overflow
);

  localparam int unsigned CNT_W = $clog2(SAMPLES_PER_CHIP) + 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SAMPLES_PER_CHIP / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_CHIP - 1);

  logic clk, rst;
  assign clk = s00_axis_aclk;
  assign rst = s00_axis_areset;

  // Samples arrive every cycle, so input valid carries no information
  logic unused_tvalid;
  assign unused_tvalid   = s00_axis_tvalid;
  assign s00_axis_tready = 1'b1;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       samp_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [LONG_BITS-1:0]   sr;
  logic [VIOL_W-1:0]      viol;
  logic                   first_chip;
  logic                   long_frame;

  logic                   out_valid;
  logic [LONG_BITS-1:0]   out_data;
  logic [TUSER_W-1:0]     out_user;

  logic start_c, sample_c, decode_c, abort_c, done_c;
  logic chip_c, pair_bad_c, dec_bit_c, viol_over_c, long_next_c, last_bit_c, crc_ok_c;
  logic [VIOL_W-1:0]      viol_inc_c;
  logic [LONG_BITS-1:0]   sr_next_c;

  // Chip slicing and pair decode
  assign chip_c      = s00_axis_tdata > decoder_threshold;
  assign pair_bad_c  = first_chip == chip_c;
  assign dec_bit_c   = first_chip & ~chip_c;
  assign viol_inc_c  = viol + VIOL_W'(pair_bad_c);
  assign viol_over_c = pair_bad_c && ((7'(viol) + 7'd1) > 7'(MAX_ERRORS));
  assign sr_next_c   = {sr[LONG_BITS-2:0], dec_bit_c};

  // Length is fixed once the five DF bits are in; before that assume long
  assign long_next_c = (bit_cnt == BIT_W'(4)) ? (sr_next_c[4:0] >= 5'(DF_LONG_MIN))
                                              : long_frame;
  assign last_bit_c  = bit_cnt == (long_next_c ? BIT_W'(LONG_BITS - 1)
                                               : BIT_W'(SHORT_BITS - 1));

`ifdef ADSB_CRC_EN
  logic [CRC_W-1:0] crc_next_c;

  adsb_crc24 u_crc24 (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_c),
    .en         (decode_c),
    .din        (dec_bit_c),
    .crc_next_c (crc_next_c)
  );

  assign crc_ok_c = crc_next_c == '0;
`else
  assign crc_ok_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next state and per-cycle strobes
  always_comb begin
    state_n  = state;
    start_c  = 1'b0;
    sample_c = 1'b0;
    decode_c = 1'b0;
    abort_c  = 1'b0;
    done_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          start_c = 1'b1;
          state_n = ST_FIRST_CHIP;
        end
      end
      ST_FIRST_CHIP: begin
        // Bit 0 is reached half a chip early to land mid-chip after the preamble
        if (samp_cnt == ((bit_cnt == '0) ? CNT_HALF : CNT_LAST)) begin
          sample_c = 1'b1;
          state_n  = ST_SECOND_CHIP;
        end
      end
      ST_SECOND_CHIP: begin
        if (samp_cnt == CNT_LAST) begin
          decode_c = 1'b1;
          if (viol_over_c) begin
            abort_c = 1'b1;
            state_n = ST_IDLE;
          end else if (last_bit_c) begin
            done_c  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_FIRST_CHIP;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Counters, shift register and one-entry output register
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt       <= '0;
      bit_cnt        <= '0;
      sr             <= '0;
      viol           <= '0;
      first_chip     <= 1'b0;
      long_frame     <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_user       <= '0;
      frame_abort    <= 1'b0;
      frame_overflow <= 1'b0;
    end else begin
      frame_abort    <= abort_c;
      frame_overflow <= 1'b0;

      if (start_c) begin
        samp_cnt   <= CNT_W'(TRIGGER_DELAY);
        bit_cnt    <= '0;
        sr         <= '0;
        viol       <= '0;
        first_chip <= 1'b0;
        long_frame <= 1'b1;
      end else if (sample_c) begin
        first_chip <= chip_c;
        samp_cnt   <= '0;
      end else if (decode_c) begin
        samp_cnt   <= '0;
        sr         <= sr_next_c;
        viol       <= viol_inc_c;
        bit_cnt    <= bit_cnt + BIT_W'(1);
        long_frame <= long_next_c;
      end else if (state != ST_IDLE) begin
        samp_cnt <= samp_cnt + CNT_W'(1);
      end

      // A completion while the held frame is stalled is dropped; one that
      // coincides with the handshake replaces it
      if (done_c) begin
        if (out_valid && !m00_axis.tready) begin
          frame_overflow <= 1'b1;
        end else begin
          out_valid <= 1'b1;
          out_data  <= long_next_c ? sr_next_c
                                   : {sr_next_c[SHORT_BITS-1:0], SHORT_BITS'(0)};
          out_user  <= {viol_inc_c, crc_ok_c, long_next_c};
        end
      end else if (out_valid && m00_axis.tready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign m00_axis.tvalid = out_valid;
  assign m00_axis.tdata  = out_data;
  assign m00_axis.tuser  = out_user;
  assign m00_axis.tlast  = 1'b1;

endmodule

// File: tb/tb_adsb_frame_decoder.sv
// Self-checking bench for adsb_frame_decoder: drives chip-level magnitude
// waveforms after a trigger, pushes the expected frame into a scoreboard and
// compares it when the output handshake happens.
module tb_adsb_frame_decoder;

  localparam int unsigned MAX_ERR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tready;
  logic        trigger = 1'b0;
  logic [31:0] threshold = 32'd100;
  logic        frame_abort, frame_overflow;

  adsb_frame_decoder_if m00_axis ();

  adsb_frame_decoder dut (
    .s00_axis_aclk     (clk),
    .s00_axis_areset   (rst),
    .s00_axis_tvalid   (s_tvalid),
    .s00_axis_tdata    (s_tdata),
    .s00_axis_tready   (s_tready),
    .trigger           (trigger),
    .decoder_threshold (threshold),
    .m00_axis          (m00_axis),
    .frame_abort       (frame_abort),
    .frame_overflow    (frame_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [111:0] data;
    logic [7:0]   user;
    int           rise;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] crc24(input logic [111:0] b, input int n);
    logic [23:0] c;
    logic        fb;
    c = '0;
    for (int i = 0; i < n; i++) begin
      fb = b[111-i] ^ c[23];
      c  = {c[22:0], 1'b0};
      if (fb) c = c ^ 24'hFFF409;
    end
    return c;
  endfunction

  // Left-aligned frame with a valid parity field
  function automatic logic [111:0] make_frame(input logic [4:0] df, input int n);
    logic [95:0]  r;
    logic [111:0] f;
    r = {$urandom(), $urandom(), $urandom()};
    f = '0;
    if (n == 112) begin
      f[111:24] = {df, r[82:0]};
      f[23:0]   = crc24(f, 88);
    end else begin
      f[111:80] = {df, r[26:0]};
      f[79:56]  = crc24(f, 32);
    end
    return f;
  endfunction

  // Output monitor, sampled mid-cycle after the negedge drivers
  int abort_cnt = 0, last_abort_cyc = 0, ovf_cnt = 0, hs_cnt = 0, rise_cyc = 0;
  logic prev_tv = 1'b0;
  always @(negedge clk) begin
    #1;
    if (m00_axis.tvalid && !prev_tv) rise_cyc = cyc;
    prev_tv = m00_axis.tvalid;
    if (frame_abort) begin
      abort_cnt++;
      last_abort_cyc = cyc;
    end
    if (frame_overflow) ovf_cnt++;
    if (m00_axis.tvalid && m00_axis.tready && !rst) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tdata", m00_axis.tdata, e.data);
        check("tuser", m00_axis.tuser, e.user);
        check("rise_cycle", rise_cyc, e.rise);
      end
    end
  end

  task automatic send_frame(input logic [111:0] bits, input int n, input logic [111:0] vmask,
                            input int retrig_d, input int rst_d, input bit drop);
    logic [111:0] ex;
    int           nv, abort_k, t0, last_d, j, bi, abort0;
    logic         b, v, crc_ok;
    exp_t         e;
    ex = bits; nv = 0; abort_k = -1;
    for (int i = 0; i < n; i++) begin
      if (vmask[111-i]) begin
        ex[111-i] = 1'b0;
        nv++;
        if (nv == MAX_ERR + 1) abort_k = i;
      end
    end
`ifdef ADSB_CRC_EN
    crc_ok = crc24(ex, n) == 24'd0;
`else
    crc_ok = 1'b0;
`endif
    @(negedge clk);
    t0 = cyc;
    if (abort_k < 0 && rst_d == 0 && !drop) begin
      e.data = (n == 112) ? ex : {ex[111:56], 56'd0};
      e.user = {6'(nv), crc_ok, n == 112};
      e.rise = t0 + 47 + 64 * (n - 1);
      sb.push_back(e);
    end
    abort0  = abort_cnt;
    trigger = 1'b1;
    last_d  = (rst_d > 0) ? rst_d + 5 : 64 * n - 16;
    for (int d = 0; d <= last_d; d++) begin
      if (d > 0) @(negedge clk);
      if (d > 0) trigger = (d == retrig_d);
      rst = (d == rst_d) && (rst_d > 0);
      j   = (d + 2) / 32;
      bi  = j / 2;
      if (bi < n) begin
        b = bits[111-bi];
        v = vmask[111-bi];
        s_tdata = (v || ((j % 2 == 0) ? b : !b)) ? 32'd200 : 32'd0;
      end else begin
        s_tdata = 32'd0;
      end
    end
    trigger = 1'b0;
    rst     = 1'b0;
    s_tdata = '0;
    if (abort_k >= 0) begin
      #1;
      check("abort_count", abort_cnt - abort0, 1);
      check("abort_cycle", last_abort_cyc, t0 + 47 + 64 * abort_k);
      check("abort_tvalid", m00_axis.tvalid, 0);
    end
  endtask

  logic [111:0] f, vm;
  int ovf0, hs0;

  initial begin
    m00_axis.tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tvalid", m00_axis.tvalid, 0);
    check("rst_tdata", m00_axis.tdata, 0);
    check("rst_tuser", m00_axis.tuser, 0);
    check("rst_abort", frame_abort, 0);
    check("rst_overflow", frame_overflow, 0);
    check("tlast", m00_axis.tlast, 1);
    check("s_tready", s_tready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Clean DF17 and DF11
    send_frame(make_frame(5'd17, 112), 112, '0, 0, 0, 1'b0);
    send_frame(make_frame(5'd11, 56), 56, '0, 0, 0, 1'b0);

    // Three violations tolerated, five abort
    vm = '0; vm[111-20] = 1'b1; vm[111-40] = 1'b1; vm[111-60] = 1'b1;
    send_frame(make_frame(5'd17, 112), 112, vm, 0, 0, 1'b0);
    vm = '0;
    for (int k = 1; k <= 5; k++) vm[111-10*k] = 1'b1;
    send_frame(make_frame(5'd17, 112), 112, vm, 0, 0, 1'b0);

    // Back-to-back with the sink stalled: second frame dropped
    m00_axis.tready = 1'b0;
    ovf0 = ovf_cnt;
    hs0  = hs_cnt;
    send_frame(make_frame(5'd17, 112), 112, '0, 0, 0, 1'b0);
    send_frame(make_frame(5'd11, 56), 56, '0, 0, 0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("overflow_count", ovf_cnt - ovf0, 1);
    check("held_tvalid", m00_axis.tvalid, 1);
    m00_axis.tready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("drain_handshakes", hs_cnt - hs0, 1);
    check("drain_tvalid", m00_axis.tvalid, 0);

    // Re-trigger mid-frame ignored
    send_frame(make_frame(5'd17, 112), 112, '0, 1000, 0, 1'b0);

    // Reset mid-frame, then a normal frame
    send_frame(make_frame(5'd17, 112), 112, '0, 0, 2000, 1'b0);
    #1;
    check("midrst_tvalid", m00_axis.tvalid, 0);
    check("midrst_tdata", m00_axis.tdata, 0);
    send_frame(make_frame(5'd17, 112), 112, '0, 0, 0, 1'b0);

    // Single flipped data bit
    f = make_frame(5'd17, 112);
    f[111-50] = ~f[111-50];
    send_frame(f, 112, '0, 0, 0, 1'b0);

    repeat (20) @(negedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adsb_frame_decoder.md
# adsb_frame_decoder

Parametrised Manchester/PPM squitter decoder that replaces the fixed 112-bit decoder behind the CORDIC magnitude stream and preamble trigger. It samples each chip mid-period, selects the 56-bit or 112-bit frame length from the downlink format (DF) field, and counts chip-pair violations, aborting frames that exceed a limit. It holds each frame in a one-entry output register under a real AXIS ready handshake, with an optional CRC-24 check.

## Interface
- MAG_WIDTH, 32, magnitude sample width
- SAMPLES_PER_CHIP, 32, samples per 0.5 us chip (64 MSps)
- TRIGGER_DELAY, 3, initial sample-counter value compensating the local-max detector latency
- MAX_ERRORS, 4, chip-pair violations tolerated per frame (≤ 63)
- s00_axis_aclk  in  1  single clock
- s00_axis_areset  in  1  reset; synchronous and active-high
- s00_axis_tvalid  in  1  magnitude valid (ignored; samples arrive every cycle)
- s00_axis_tdata  in  MAG_WIDTH  magnitude
- s00_axis_tready  out  1  constant 1
- trigger  in  1  preamble-detected pulse
- decoder_threshold  in  MAG_WIDTH  chip is 1 iff tdata > threshold (strict)
- m00_axis_tvalid  out  1  frame valid
- m00_axis_tready  in  1  downstream ready
- m00_axis_tdata  out  112  frame, MSB = first bit; 56-bit frames left-aligned, tdata[55:0] = 0
- m00_axis_tuser  out  8  [0] long frame, [1] crc_ok, [7:2] violation count
- m00_axis_tlast  out  1  constant 1
- frame_abort  out  1  one-cycle pulse when a frame is aborted
- frame_overflow  out  1  one-cycle pulse when a completed frame is dropped

## Operation
- States: IDLE, FIRST_CHIP, SECOND_CHIP.
- IDLE: on trigger, load the sample counter with TRIGGER_DELAY and zero the bit counter, shift register, violation count and CRC. Target length = 112. Go to FIRST_CHIP.
- FIRST_CHIP: sample when counter == SAMPLES_PER_CHIP/2 (bit 0) or SAMPLES_PER_CHIP-1 (other bits). Latch the chip, clear the counter, go to SECOND_CHIP. Otherwise increment the counter.
- SECOND_CHIP: at counter == SAMPLES_PER_CHIP-1, decode the pair.
  - "10" → 1; "01" → 0.
  - "00" or "11" → 0 and violation count +1.
  - If the count would exceed MAX_ERRORS: pulse frame_abort, go to IDLE, output untouched.
- After bit 4 is decoded: DF = first five bits. DF ≥ 16 → target 112, else 56.
- After bit target-1: load the output register (left-aligned), set tuser, go to IDLE.
- Output register:
  - tvalid stays high until the cycle tvalid & tready, then clears.
  - Frame completing while tvalid & ~tready: new frame dropped, frame_overflow pulses, held frame unchanged.
  - Completion in the same cycle as the handshake: new frame loads, tvalid stays 1.
- Trigger outside IDLE is ignored (no restart).
- Reset mid-frame: immediate return to IDLE, partial frame discarded.
- Reset values: tvalid 0, tdata 0, tuser 0, frame_abort 0, frame_overflow 0, counters 0, state IDLE.

## Timing
- Trigger at cycle T → bit 0 first chip sampled at T+1+(SAMPLES_PER_CHIP/2−TRIGGER_DELAY); defaults give T+14.
- Each further chip is sampled SAMPLES_PER_CHIP cycles after the previous one.
- Bit k is decoded at T+14+32+64k (defaults).
- tvalid rises at T+47+64(N−1): T+7151 for N=112, T+3567 for N=56.
- frame_abort fires in the cycle after the offending decode.
- New trigger is accepted from the first cycle back in IDLE.

## Configuration
- ADSB_CRC_EN defined: a serial CRC-24 (poly 0xFFF409, zero init) runs over all N bits. crc_ok (tuser[1]) = remainder == 0. Adds no latency.
- ADSB_CRC_EN undefined: no CRC logic; tuser[1] is tied 0.

## Structure
- Package adsb_pkg: state enum; LONG_BITS=112, SHORT_BITS=56, CRC_POLY=24'hFFF409, DF_LONG_MIN=16; tuser field offsets.
- Sub-module adsb_crc24: bit-serial CRC with clear, bit-enable and data inputs; instantiated only under ADSB_CRC_EN.

## Test plan
- Clean DF17 frame, threshold 100, magnitudes 0/200, ready=1 → tvalid at T+7151, tdata equals frame, tuser[0]=1, count 0, crc_ok=1 (CRC_EN).
- DF11 56-bit frame → tvalid at T+3567, tdata[111:56] equals frame, tdata[55:0]=0, tuser[0]=0.
- DF17 frame with 3 "11" pairs → decoded, count=3. With 5 pairs → frame_abort at the 5th, tvalid stays 0.
- Two back-to-back frames with ready=0 → first frame held, frame_overflow pulses once at second completion. ready=1 afterwards → one handshake.
- Re-trigger at T+1000 mid-frame → ignored, frame matches. Reset at T+2000 → IDLE, tvalid 0, next trigger decodes normally.
- One DF17 frame with a single flipped data bit, CRC_EN → crc_ok=0.
